dbus_sram_ctrl: RTL and testbench

- Avalon-MM responder on the core data bus. Serves word requests from the load/store unit and drives an external asynchronous 16-bit SRAM.
- Each 32-bit word is transferred as two halfword SRAM accesses: low half first, then high half.
- Holds `waitrequest` high until the transfer completes. Read data is registered and held stable from the cycle after acceptance, which is when the requester's MEM stage samples it.

---
 rtl/dbus_sram_pkg.sv | 41 ++++
 rtl/sram_phase_timer.sv | 38 +++
 rtl/dbus_sram_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dbus_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_sram_pkg.sv
// -----------------------------------------------------------------------------
// dbus_sram_pkg
// Shared types and constants for the data-bus SRAM controller.
//   - sram_state_t : controller FSM states (IDLE / LO / HI / ACK)
//   - HALF_LO/HI   : halfword select values, also the SRAM address LSB
//   - avalon_req_t : requester -> responder bundle (read, write, address,
//                    writedata, byte_enable)
//   - avalon_resp_t: responder -> requester bundle (readdata, waitrequest)
//   - select_lanes : picks the two byte enables belonging to one halfword
// -----------------------------------------------------------------------------
package dbus_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } sram_state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byte_enable;
    } avalon_req_t;

    typedef struct packed {
        logic [31:0] readdata;
        logic        waitrequest;
    } avalon_resp_t;

    // Byte enables of the selected halfword: {upper lane, lower lane}.
    function automatic logic [1:0] select_lanes(input logic [3:0] be, input logic half);
        return (half == HALF_HI) ? be[3:2] : be[1:0];
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// -----------------------------------------------------------------------------
// sram_phase_timer
// Loadable down-counter that times one SRAM halfword phase.
//   clk, rst    : clock and synchronous active-high reset
//   load        : load load_value on this edge (phase entry)
//   load_value  : cycles remaining minus one for the phase being entered
//   count       : current remaining count; 0 marks the last phase cycle
//   phase_done  : high while count is 0 (last cycle of the phase)
// The counter parks at zero, so phase_done is also high while idle; the
// controller only looks at it inside a phase.
// -----------------------------------------------------------------------------
module sram_phase_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic [CW-1:0] count,
    output logic          phase_done
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count      = count_reg;
    assign phase_done = (count_reg == '0);

endmodule

// File: rtl/dbus_sram_ctrl.sv
// -----------------------------------------------------------------------------
// dbus_sram_ctrl
// Avalon-MM responder for the core data bus driving an asynchronous 16-bit
// SRAM. Each 32-bit word moves as two halfword accesses, low half first.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   dbus_avalon_req   : read/write/address/writedata/byte_enable
//   dbus_avalon_resp  : readdata (registered), waitrequest (combinational)
//   sram_addr         : halfword address {word index, half}
//   sram_dq_out       : write data for the DQ pad
//   sram_dq_oe        : DQ pad drive enable
//   sram_dq_in        : read data from the DQ pad
//   sram_ce_n/oe_n/we_n/lb_n/ub_n : active-low SRAM strobes
//
// Parameters:
//   SRAM_AW       : halfword address width; byte address [SRAM_AW:2] is the
//                   word index, higher address bits alias
//   ACCESS_CYCLES : cycles per read phase; write phases add one hold cycle
//
// Optional feature: define DBUS_SRAM_READ_BUF_EN for a one-entry read buffer
// (valid + word tag) that lets a repeated read skip the SRAM entirely.
//
// All SRAM pins are decoded from registered state only, so they are glitch
// free with respect to the request inputs.
// -----------------------------------------------------------------------------
module dbus_sram_ctrl
    import dbus_sram_pkg::*;
#(
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  avalon_req_t        dbus_avalon_req,
    output avalon_resp_t       dbus_avalon_resp,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    // Counter must hold ACCESS_CYCLES (write phase load value).
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(ACCESS_CYCLES);

    sram_state_t        state_reg;
    logic               is_write_reg;
    logic [SRAM_AW-2:0] addr_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         be_reg;
    logic [15:0]        stage_lo_reg;
    logic [15:0]        stage_hi_reg;
    logic [31:0]        readdata_reg;

    logic [SRAM_AW-2:0] req_word;
    logic               buffer_hit;
    logic               timer_load;
    logic [CW-1:0]      timer_load_value;
    logic [CW-1:0]      timer_count;
    logic               phase_done;
    logic               in_phase;
    logic               half;
    logic [1:0]         lanes;

    assign req_word = dbus_avalon_req.address[SRAM_AW:2];

    // Byte-offset bits and aliased upper address bits carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dbus_avalon_req.address[1:0],
                                dbus_avalon_req.address[31:SRAM_AW+1]};

`ifdef DBUS_SRAM_READ_BUF_EN
    logic               buf_valid_reg;
    logic [SRAM_AW-2:0] buf_tag_reg;
    assign buffer_hit = buf_valid_reg && (req_word == buf_tag_reg);
`else
    assign buffer_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Phase timer load: issued on the edge that enters LO or HI.
    // ------------------------------------------------------------------
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = RD_LOAD;
        case (state_reg)
            IDLE: begin
                if (dbus_avalon_req.write) begin
                    timer_load       = (dbus_avalon_req.byte_enable != 4'b0000);
                    timer_load_value = WR_LOAD;
                end else if (dbus_avalon_req.read && !buffer_hit) begin
                    timer_load       = 1'b1;
                    timer_load_value = RD_LOAD;
                end
            end
            LO: begin
                if (phase_done && !(is_write_reg && (be_reg[3:2] == 2'b00))) begin
                    timer_load       = 1'b1;
                    timer_load_value = is_write_reg ? WR_LOAD : RD_LOAD;
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    sram_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count      (timer_count),
        .phase_done (phase_done)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            stage_lo_reg  <= '0;
            stage_hi_reg  <= '0;
            readdata_reg  <= '0;
`ifdef DBUS_SRAM_READ_BUF_EN
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Write wins when read and write are both asserted.
                    if (dbus_avalon_req.write) begin
                        addr_reg     <= req_word;
                        wdata_reg    <= dbus_avalon_req.writedata;
                        be_reg       <= dbus_avalon_req.byte_enable;
                        is_write_reg <= 1'b1;
`ifdef DBUS_SRAM_READ_BUF_EN
                        buf_valid_reg <= 1'b0;
`endif
                        if (dbus_avalon_req.byte_enable[1:0] != 2'b00) begin
                            state_reg <= LO;
                        end else if (dbus_avalon_req.byte_enable[3:2] != 2'b00) begin
                            state_reg <= HI;
                        end else begin
                            state_reg <= ACK;
                        end
                    end else if (dbus_avalon_req.read) begin
                        addr_reg     <= req_word;
                        is_write_reg <= 1'b0;
                        // On a hit the staging halves already hold the
                        // tagged word, so the ACK commit is a no-op.
                        state_reg    <= buffer_hit ? ACK : LO;
                    end
                end
                LO: begin
                    if (phase_done) begin
                        if (!is_write_reg) begin
                            stage_lo_reg <= sram_dq_in;
                        end
                        if (is_write_reg && (be_reg[3:2] == 2'b00)) begin
                            state_reg <= ACK;
                        end else begin
                            state_reg <= HI;
                        end
                    end
                end
                HI: begin
                    if (phase_done) begin
                        if (!is_write_reg) begin
                            stage_hi_reg <= sram_dq_in;
                        end
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    if (!is_write_reg) begin
                        readdata_reg <= {stage_hi_reg, stage_lo_reg};
`ifdef DBUS_SRAM_READ_BUF_EN
                        buf_tag_reg   <= addr_reg;
                        buf_valid_reg <= 1'b1;
`endif
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SRAM pin decode (registered state only)
    // ------------------------------------------------------------------
    assign in_phase = (state_reg == LO) || (state_reg == HI);
    assign half     = (state_reg == HI) ? HALF_HI : HALF_LO;
    assign lanes    = select_lanes(be_reg, half);

    always_comb begin
        sram_addr   = {addr_reg, half};
        sram_dq_out = (half == HALF_HI) ? wdata_reg[31:16] : wdata_reg[15:0];
        sram_ce_n   = !in_phase;
        sram_oe_n   = !(in_phase && !is_write_reg);
        sram_dq_oe  = in_phase && is_write_reg;
        // The final write cycle (count 0) holds data with we_n released.
        sram_we_n   = !(in_phase && is_write_reg && (timer_count != '0));
        sram_lb_n   = 1'b1;
        sram_ub_n   = 1'b1;
        if (in_phase) begin
            if (is_write_reg) begin
                sram_lb_n = !lanes[0];
                sram_ub_n = !lanes[1];
            end else begin
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
        end
    end

    assign dbus_avalon_resp = '{
        readdata:    readdata_reg,
        waitrequest: (dbus_avalon_req.read || dbus_avalon_req.write) && (state_reg != ACK)
    };

endmodule

// File: tb/tb_dbus_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbus_sram_ctrl
// Directed bench for dbus_sram_ctrl with default parameters (SRAM_AW = 18,
// ACCESS_CYCLES = 2) and a behavioural async SRAM. Build with
// DBUS_SRAM_READ_BUF_EN defined to exercise the read buffer expectations.
// -----------------------------------------------------------------------------
module tb_dbus_sram_ctrl;
    import dbus_sram_pkg::*;

    logic         clk;
    logic         rst;
    avalon_req_t  req;
    avalon_resp_t resp;
    logic [17:0]  sram_addr;
    logic [15:0]  sram_dq_out;
    logic         sram_dq_oe;
    logic [15:0]  sram_dq_in;
    logic         sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int checks = 0;
    int errors = 0;

`ifdef DBUS_SRAM_READ_BUF_EN
    localparam int HIT_WAITS = 1;
    localparam int HIT_CE    = 0;
`else
    localparam int HIT_WAITS = 5;
    localparam int HIT_CE    = 4;
`endif

    dbus_sram_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .dbus_avalon_req  (req),
        .dbus_avalon_resp (resp),
        .sram_addr        (sram_addr),
        .sram_dq_out      (sram_dq_out),
        .sram_dq_oe       (sram_dq_oe),
        .sram_dq_in       (sram_dq_in),
        .sram_ce_n        (sram_ce_n),
        .sram_oe_n        (sram_oe_n),
        .sram_we_n        (sram_we_n),
        .sram_lb_n        (sram_lb_n),
        .sram_ub_n        (sram_ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-lane writes while ce_n and we_n are low.
    logic [15:0] mem [0:(1<<18)-1];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_out[15:8];
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    // One complete bus transaction; collects per-cycle SRAM observations.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output int waits, output int ce_cyc, output int we_cyc,
                             output int lo_cyc, output int both_lanes,
                             output logic [17:0] last_addr, output int early_chg,
                             output logic [31:0] rdata);
        logic [31:0] start_rd;
        bit done;
        int n;
        waits = 0; ce_cyc = 0; we_cyc = 0; lo_cyc = 0; both_lanes = 0;
        last_addr = '0; early_chg = 0; done = 0; n = 0;
        @(posedge clk); #1;
        start_rd = resp.readdata;
        req.read = rd; req.write = wr; req.address = addr;
        req.writedata = wdata; req.byte_enable = be;
        while (!done && n < 100) begin
            @(negedge clk);
            if (!sram_ce_n) begin
                ce_cyc++;
                if (!sram_we_n) we_cyc++;
                if (!sram_addr[0]) lo_cyc++;
                if (!sram_lb_n && !sram_ub_n) both_lanes++;
                last_addr = sram_addr;
            end
            if (resp.readdata !== start_rd) early_chg++;
            if (resp.waitrequest) waits++;
            else done = 1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout: waitrequest still high after %0d cycles, required release", n);
        end
        @(posedge clk); #1;
        req = '0;
        rdata = resp.readdata;
        $display("txn rd=%0b wr=%0b addr=%h wdata=%h be=%b waits=%0d ce=%0d rdata=%h",
                 rd, wr, addr, wdata, be, waits, ce_cyc, rdata);
    endtask

    int w, ce, we, lo, both, early;
    logic [17:0] la;
    logic [31:0] rdv;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (resp.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", resp.readdata); end
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes: got %b expected 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b expected 0", sram_dq_oe); end
        checks++; if (resp.waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitrequest: got %b expected 0", resp.waitrequest); end
        checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_reg, IDLE); end
    endtask

    task automatic test_full_word();
        do_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 7) begin errors++; $display("FAIL wr_full_waits: got %0d expected 7", w); end
        checks++; if (ce !== 6) begin errors++; $display("FAIL wr_full_ce: got %0d expected 6", ce); end
        checks++; if (we !== 4) begin errors++; $display("FAIL wr_full_we: got %0d expected 4", we); end
        checks++; if (mem[18'h80] !== 16'hBEEF) begin errors++; $display("FAIL wr_full_mem_lo: got %h expected BEEF", mem[18'h80]); end
        checks++; if (mem[18'h81] !== 16'hDEAD) begin errors++; $display("FAIL wr_full_mem_hi: got %h expected DEAD", mem[18'h81]); end
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 5) begin errors++; $display("FAIL rd_full_waits: got %0d expected 5", w); end
        checks++; if (ce !== 4) begin errors++; $display("FAIL rd_full_ce: got %0d expected 4", ce); end
        checks++; if (we !== 0) begin errors++; $display("FAIL rd_full_we: got %0d expected 0", we); end
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_full_data: got %h expected DEADBEEF", rdv); end
    endtask

    task automatic test_partial_be();
        do_access(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 4'b1111, w, ce, we, lo, both, la, early, rdv);
        do_access(1'b0, 1'b1, 32'h104, 32'h11223344, 4'b1100, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 4) begin errors++; $display("FAIL be1100_waits: got %0d expected 4", w); end
        checks++; if (ce !== 3) begin errors++; $display("FAIL be1100_ce: got %0d expected 3", ce); end
        checks++; if (lo !== 0) begin errors++; $display("FAIL be1100_lo_cycles: got %0d expected 0", lo); end
        checks++; if (both !== 3) begin errors++; $display("FAIL be1100_lanes: got %0d expected 3", both); end
        checks++; if (la !== 18'h83) begin errors++; $display("FAIL be1100_addr: got %h expected 00083", la); end
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (rdv !== 32'h1122F00D) begin errors++; $display("FAIL be1100_readback: got %h expected 1122F00D", rdv); end
        do_access(1'b0, 1'b1, 32'h104, 32'h000000AA, 4'b0001, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 4) begin errors++; $display("FAIL be0001_waits: got %0d expected 4", w); end
        checks++; if (lo !== 3) begin errors++; $display("FAIL be0001_lo_cycles: got %0d expected 3", lo); end
        checks++; if (both !== 0) begin errors++; $display("FAIL be0001_lanes: got %0d expected 0", both); end
        checks++; if (la !== 18'h82) begin errors++; $display("FAIL be0001_addr: got %h expected 00082", la); end
        checks++; if (mem[18'h82] !== 16'hF0AA) begin errors++; $display("FAIL be0001_mem: got %h expected F0AA", mem[18'h82]); end
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (rdv !== 32'h1122F0AA) begin errors++; $display("FAIL be0001_readback: got %h expected 1122F0AA", rdv); end
    endtask

    task automatic test_be_zero();
        do_access(1'b0, 1'b1, 32'h104, 32'hFFFFFFFF, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 1) begin errors++; $display("FAIL be0000_waits: got %0d expected 1", w); end
        checks++; if (ce !== 0) begin errors++; $display("FAIL be0000_ce: got %0d expected 0", ce); end
        checks++; if (rdv !== 32'h1122F0AA) begin errors++; $display("FAIL be0000_readdata: got %h expected 1122F0AA", rdv); end
        checks++; if (mem[18'h82] !== 16'hF0AA) begin errors++; $display("FAIL be0000_mem: got %h expected F0AA", mem[18'h82]); end
    endtask

    task automatic test_write_priority();
        do_access(1'b1, 1'b1, 32'h108, 32'h13579BDF, 4'b1111, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 7) begin errors++; $display("FAIL prio_waits: got %0d expected 7", w); end
        checks++; if (we !== 4) begin errors++; $display("FAIL prio_we: got %0d expected 4", we); end
        checks++; if (rdv !== 32'h1122F0AA) begin errors++; $display("FAIL prio_readdata: got %h expected 1122F0AA", rdv); end
        checks++; if ({mem[18'h85], mem[18'h84]} !== 32'h13579BDF) begin
            errors++; $display("FAIL prio_mem: got %h expected 13579BDF", {mem[18'h85], mem[18'h84]}); end
    endtask

    task automatic test_read_order();
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL order_a_data: got %h expected DEADBEEF", rdv); end
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (early !== 0) begin errors++; $display("FAIL order_hold_a: got %0d early changes expected 0", early); end
        checks++; if (w !== 5) begin errors++; $display("FAIL order_b_waits: got %0d expected 5", w); end
        checks++; if (rdv !== 32'h1122F0AA) begin errors++; $display("FAIL order_b_data: got %h expected 1122F0AA", rdv); end
    endtask

    task automatic test_read_buffer();
        do_access(1'b0, 1'b1, 32'h200, 32'h55667788, 4'b1111, w, ce, we, lo, both, la, early, rdv);
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 5 || ce !== 4) begin errors++; $display("FAIL buf_first_read: got waits=%0d ce=%0d expected 5/4", w, ce); end
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== HIT_WAITS || ce !== HIT_CE) begin
            errors++; $display("FAIL buf_second_read: got waits=%0d ce=%0d expected %0d/%0d", w, ce, HIT_WAITS, HIT_CE); end
        checks++; if (rdv !== 32'h55667788) begin errors++; $display("FAIL buf_second_data: got %h expected 55667788", rdv); end
        do_access(1'b0, 1'b1, 32'h300, 32'h99AABBCC, 4'b1111, w, ce, we, lo, both, la, early, rdv);
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 5 || ce !== 4) begin errors++; $display("FAIL buf_after_write: got waits=%0d ce=%0d expected 5/4", w, ce); end
        checks++; if (rdv !== 32'h55667788) begin errors++; $display("FAIL buf_after_write_data: got %h expected 55667788", rdv); end
    endtask

    task automatic test_reset_mid_write();
        int ce_seen;
        @(posedge clk); #1;
        req.read = 1'b0; req.write = 1'b1; req.address = 32'h300;
        req.writedata = 32'h0BADF00D; req.byte_enable = 4'b1111;
        @(posedge clk); #1;
        checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'h180) begin
            errors++; $display("FAIL rstmid_lo_active: got we_n=%b addr=%h expected 0/00180", sram_we_n, sram_addr); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1) begin
            errors++; $display("FAIL rstmid_pins: got we_n=%b dq_oe=%b ce_n=%b expected 1/0/1", sram_we_n, sram_dq_oe, sram_ce_n); end
        checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_reg, IDLE); end
        checks++; if (resp.readdata !== 32'h0) begin errors++; $display("FAIL rstmid_readdata: got %h expected 00000000", resp.readdata); end
        rst = 1'b0;
        req = '0;
        ce_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!sram_ce_n) ce_seen++;
        end
        checks++; if (ce_seen !== 0) begin errors++; $display("FAIL rstmid_no_restart: got %0d ce cycles expected 0", ce_seen); end
        checks++; if (mem[18'h181] !== 16'h99AA) begin errors++; $display("FAIL rstmid_hi_untouched: got %h expected 99AA", mem[18'h181]); end
        do_access(1'b1, 1'b0, 32'h200, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (w !== 5 || ce !== 4) begin errors++; $display("FAIL rstmid_buf_cleared: got waits=%0d ce=%0d expected 5/4", w, ce); end
        checks++; if (rdv !== 32'h55667788) begin errors++; $display("FAIL rstmid_read_200: got %h expected 55667788", rdv); end
        do_access(1'b1, 1'b0, 32'h300, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (rdv[31:16] !== 16'h99AA) begin errors++; $display("FAIL rstmid_read_300_hi: got %h expected 99AA", rdv[31:16]); end
    endtask

    task automatic test_alias();
        do_access(1'b1, 1'b0, 32'h0008_0100, 32'h0, 4'b0000, w, ce, we, lo, both, la, early, rdv);
        checks++; if (la !== 18'h81) begin errors++; $display("FAIL alias_addr: got %h expected 00081", la); end
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_data: got %h expected DEADBEEF", rdv); end
    endtask

    initial begin
        req = '0;
        rst = 1'b1;
        for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0000;
        test_reset();
        test_full_word();
        test_partial_be();
        test_be_zero();
        test_write_priority();
        test_read_order();
        test_read_buffer();
        test_reset_mid_write();
        test_alias();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
